// File: rtl/omsp_trace_buffer.sv
// Instruction trace capture for one MSP430 core: circular entry buffer with
// PC-match trigger, post-trigger window and a registered pop/valid read port.
module omsp_trace_buffer #(
    parameter int DEPTH_LOG2 = 4,
    parameter int CYC_W      = 8
) (
    input  logic                  mclk,
    input  logic                  puc_rst,
    input  logic                  decode,
    input  logic [15:0]           ir,
    input  logic [15:0]           pc,
    input  logic                  irq_detect,
    input  logic [3:0]            irq_num,
    input  logic                  trc_en,
    input  logic                  trc_wrap,
    input  logic                  trc_clr,
    input  logic                  trig_en,
    input  logic [15:0]           trig_pc,
    input  logic [DEPTH_LOG2:0]   post_cnt,
    input  logic                  rd_req,
    output logic [36+CYC_W:0]     rd_data,
    output logic                  rd_valid,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  triggered,
    output logic [1:0]            trc_state
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int ENT_W = 37 + CYC_W;
    localparam int LVL_W = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [CYC_W-1:0]      cyc_cnt;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0]      remaining;
    logic [ENT_W-1:0]      mem [DEPTH];
    logic [ENT_W-1:0]      entry;

    logic cap, wr, pop, do_write, drop_oldest, lost, trig_hit, post_step;

    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign entry       = {irq_detect, irq_num, pc, ir, cyc_cnt};
    assign cap         = decode & ((state == ARMED) | (state == POST));
    assign wr          = cap & ~trc_clr;
    assign pop         = rd_req & ~empty & ~trc_clr;
    // A full buffer still accepts a write if a pop frees a slot or wrapping is on.
    assign do_write    = wr & (~full | pop | trc_wrap);
    assign drop_oldest = do_write & full & ~pop;
    assign lost        = wr & full & ~pop;
    assign trig_hit    = cap & trc_en & ~trc_clr & (state == ARMED) & trig_en & (pc == trig_pc);
    assign post_step   = cap & trc_en & ~trc_clr & (state == POST);

    assign empty     = (level == '0);
    assign full      = (level == LVL_W'(DEPTH));
    assign trc_state = state;

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (trc_clr) begin
            state_nxt = trc_en ? ARMED : IDLE;
        end else if (!trc_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ARMED;
                ARMED:   if (trig_hit) state_nxt = (post_cnt == '0) ? DONE : POST;
                POST:    if (post_step && (remaining <= LVL_W'(1))) state_nxt = DONE;
                DONE:    state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            cyc_cnt   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            remaining <= '0;
            overflow  <= 1'b0;
            triggered <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            cyc_cnt  <= decode ? '0 : sat_inc(cyc_cnt);
            rd_valid <= pop;
            if (pop) rd_data <= mem[rd_ptr];

            if (trc_clr) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                level     <= '0;
                remaining <= '0;
                overflow  <= 1'b0;
                triggered <= 1'b0;
            end else begin
                if (do_write)            wr_ptr <= wr_ptr + 1'b1;
                if (pop || drop_oldest)  rd_ptr <= rd_ptr + 1'b1;
                if (do_write && !pop && !full)  level <= level + 1'b1;
                else if (pop && !do_write)      level <= level - 1'b1;
                if (lost)     overflow  <= 1'b1;
                if (trig_hit) triggered <= 1'b1;
                if (trig_hit)
                    remaining <= post_cnt;
                else if (post_step && (remaining != '0))
                    remaining <= remaining - 1'b1;
            end
        end
    end

    // Storage array carries no reset; pointers and level define what is valid.
    always_ff @(posedge mclk) begin
        if (do_write) mem[wr_ptr] <= entry;
    end

endmodule

// File: tb/tb_omsp_trace_buffer.sv
// Self-checking bench for omsp_trace_buffer: directed scenarios plus a random
// run, all compared against a queue-based behavioural model.
module tb_omsp_trace_buffer;

    logic        mclk = 1'b0;
    logic        puc_rst = 1'b1;
    logic        decode = 1'b0;
    logic [15:0] ir = '0;
    logic [15:0] pc = '0;
    logic        irq_detect = 1'b0;
    logic [3:0]  irq_num = '0;
    logic        trc_en = 1'b0;
    logic        trc_wrap = 1'b0;
    logic        trc_clr = 1'b0;
    logic        trig_en = 1'b0;
    logic [15:0] trig_pc = '0;
    logic [4:0]  post_cnt = '0;
    logic        rd_req = 1'b0;
    logic [44:0] rd_data;
    logic        rd_valid;
    logic [4:0]  level;
    logic        empty, full, overflow, triggered;
    logic [1:0]  trc_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [44:0] m_q[$];
    int          m_state;
    bit          m_trig, m_ovf, m_rd_valid;
    int          m_rem, m_cyc;
    logic [44:0] m_rd_data;

    omsp_trace_buffer dut (
        .mclk(mclk), .puc_rst(puc_rst), .decode(decode), .ir(ir), .pc(pc),
        .irq_detect(irq_detect), .irq_num(irq_num), .trc_en(trc_en),
        .trc_wrap(trc_wrap), .trc_clr(trc_clr), .trig_en(trig_en),
        .trig_pc(trig_pc), .post_cnt(post_cnt), .rd_req(rd_req),
        .rd_data(rd_data), .rd_valid(rd_valid), .level(level), .empty(empty),
        .full(full), .overflow(overflow), .triggered(triggered),
        .trc_state(trc_state)
    );

    always #5 mclk = ~mclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_q.delete();
        m_state = 0; m_trig = 0; m_ovf = 0; m_rem = 0; m_cyc = 0;
        m_rd_valid = 0; m_rd_data = '0;
    endtask

    // Applies the current inputs to the model, then advances one clock.
    task automatic cycle();
        logic [44:0] e;
        bit cap;
        cap = decode && (m_state == 1 || m_state == 2);
        e = {irq_detect, irq_num, pc, ir, 8'(m_cyc)};
        if (decode) m_cyc = 0;
        else if (m_cyc < 255) m_cyc++;
        m_rd_valid = 0;
        if (trc_clr) begin
            m_q.delete();
            m_ovf = 0; m_trig = 0; m_rem = 0;
            m_state = trc_en ? 1 : 0;
        end else begin
            if (rd_req && m_q.size() > 0) begin
                m_rd_data = m_q.pop_front();
                m_rd_valid = 1;
            end
            if (cap) begin
                if (m_q.size() < 16) m_q.push_back(e);
                else if (trc_wrap) begin
                    void'(m_q.pop_front());
                    m_q.push_back(e);
                    m_ovf = 1;
                end else m_ovf = 1;
            end
            if (!trc_en) m_state = 0;
            else if (m_state == 0) m_state = 1;
            else if (m_state == 1) begin
                if (cap && trig_en && pc == trig_pc) begin
                    m_trig = 1;
                    m_rem = int'(post_cnt);
                    m_state = (post_cnt == 0) ? 3 : 2;
                end
            end else if (m_state == 2 && cap) begin
                m_rem--;
                if (m_rem == 0) m_state = 3;
            end
        end
        @(posedge mclk);
        #1;
    endtask

    task automatic reset_dut();
        decode = 0; rd_req = 0; trc_clr = 0; trc_en = 0; trc_wrap = 0;
        trig_en = 0; irq_detect = 0; irq_num = 0; post_cnt = 0;
        puc_rst = 1;
        repeat (2) @(posedge mclk);
        #1;
        puc_rst = 0;
        model_reset();
    endtask

    task automatic idle(input int n);
        decode = 0; rd_req = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic dec(input logic [15:0] p);
        decode = 1; pc = p; ir = 16'($urandom);
        cycle();
        decode = 0;
    endtask

    task automatic test_reset();
        reset_dut();
        n_checks++; if (level !== 5'd0)   begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
        n_checks++; if (empty !== 1'b1)   begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
        n_checks++; if (full !== 1'b0)    begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        n_checks++; if (triggered !== 1'b0) begin n_fail++; $display("FAIL reset_triggered got=%b exp=0", triggered); end
        n_checks++; if (trc_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", trc_state); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        n_checks++; if (rd_data !== 45'd0) begin n_fail++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    endtask

    task automatic test_cycle_delta();
        logic [7:0] exp_cyc [3];
        exp_cyc[0] = 8'd1; exp_cyc[1] = 8'd3; exp_cyc[2] = 8'd255;
        reset_dut();
        trc_en = 1;
        idle(1);
        dec(16'hC000); idle(3);
        dec(16'hC002); idle(299);
        dec(16'hC004);
        for (int i = 0; i < 3; i++) begin
            rd_req = 1; cycle(); rd_req = 0;
            n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL cyc_pop_valid[%0d] got=%b exp=1", i, rd_valid); end
            n_checks++; if (rd_data !== m_rd_data) begin n_fail++; $display("FAIL cyc_pop_data[%0d] got=%h exp=%h", i, rd_data, m_rd_data); end
            n_checks++; if (rd_data[7:0] !== exp_cyc[i]) begin n_fail++; $display("FAIL cyc_field[%0d] got=%0d exp=%0d", i, rd_data[7:0], exp_cyc[i]); end
            n_checks++; if (rd_data[39:24] !== 16'hC000 + 16'(2*i)) begin n_fail++; $display("FAIL cyc_order[%0d] got=%h", i, rd_data[39:24]); end
        end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL cyc_empty got=%b exp=1", empty); end
        rd_req = 1; cycle(); rd_req = 0;
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL pop_empty_valid got=%b exp=0", rd_valid); end
        n_checks++; if (rd_data[39:24] !== 16'hC004) begin n_fail++; $display("FAIL rd_data_hold got=%h exp=c004", rd_data[39:24]); end
    endtask

    task automatic test_fill(input bit wrap);
        reset_dut();
        trc_en = 1; trc_wrap = wrap;
        idle(1);
        for (int i = 0; i < 20; i++) dec(16'(i));
        n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL fill%0d_level got=%0d exp=16", wrap, level); end
        n_checks++; if (full !== 1'b1)   begin n_fail++; $display("FAIL fill%0d_full got=%b exp=1", wrap, full); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill%0d_overflow got=%b exp=1", wrap, overflow); end
        rd_req = 1;
        for (int i = 0; i < 16; i++) begin
            cycle();
            n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL fill%0d_valid[%0d] got=%b", wrap, i, rd_valid); end
            n_checks++; if (rd_data[39:24] !== 16'(wrap ? i + 4 : i)) begin n_fail++; $display("FAIL fill%0d_pc[%0d] got=%h exp=%h", wrap, i, rd_data[39:24], 16'(wrap ? i + 4 : i)); end
        end
        rd_req = 0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fill%0d_empty got=%b exp=1", wrap, empty); end
    endtask

    task automatic test_trigger();
        reset_dut();
        trc_en = 1; trig_en = 1; trig_pc = 16'hF010; post_cnt = 5'd2;
        idle(1);
        for (int k = 0; k < 6; k++) dec(16'hF00C + 16'(2*k));
        n_checks++; if (level !== 5'd5)   begin n_fail++; $display("FAIL trig_level got=%0d exp=5", level); end
        n_checks++; if (triggered !== 1'b1) begin n_fail++; $display("FAIL trig_flag got=%b exp=1", triggered); end
        n_checks++; if (trc_state !== 2'd3) begin n_fail++; $display("FAIL trig_state got=%0d exp=3", trc_state); end
        rd_req = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_checks++; if (rd_data[39:24] !== 16'hF00C + 16'(2*i)) begin n_fail++; $display("FAIL trig_pc[%0d] got=%h", i, rd_data[39:24]); end
        end
        rd_req = 0;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL trig_empty got=%b exp=1", empty); end
    endtask

    task automatic test_irq_full_pop();
        reset_dut();
        trc_en = 1;
        idle(1);
        for (int i = 0; i < 16; i++) dec(16'h0200 + 16'(i));
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL irq_prefull got=%b exp=1", full); end
        decode = 1; pc = 16'h0300; ir = 16'h1300; irq_detect = 1; irq_num = 4'hE; rd_req = 1;
        cycle();
        decode = 0; irq_detect = 0; irq_num = 0; rd_req = 0;
        n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL irq_level got=%0d exp=16", level); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL irq_overflow got=%b exp=0", overflow); end
        n_checks++; if (rd_valid !== 1'b1 || rd_data[39:24] !== 16'h0200) begin n_fail++; $display("FAIL irq_same_pop got=%b/%h exp=1/0200", rd_valid, rd_data[39:24]); end
        rd_req = 1;
        for (int i = 0; i < 16; i++) begin
            cycle();
            n_checks++; if (rd_data !== m_rd_data) begin n_fail++; $display("FAIL irq_drain[%0d] got=%h exp=%h", i, rd_data, m_rd_data); end
        end
        rd_req = 0;
        n_checks++; if (rd_data[44:24] !== {1'b1, 4'hE, 16'h0300}) begin n_fail++; $display("FAIL irq_entry got=%h exp=1e0300", rd_data[44:24]); end
    endtask

    task automatic test_async_reset();
        reset_dut();
        trc_en = 1; trig_en = 1; trig_pc = 16'h4006; post_cnt = 5'd10;
        idle(1);
        for (int k = 0; k < 7; k++) dec(16'h4000 + 16'(2*k));
        decode = 1; pc = 16'h400E; rd_req = 1;
        cycle();
        decode = 0; rd_req = 0;
        n_checks++; if (level !== 5'd7 || trc_state !== 2'd2) begin n_fail++; $display("FAIL arst_pre got=%0d/%0d exp=7/2", level, trc_state); end
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre_valid got=%b exp=1", rd_valid); end
        #2;
        puc_rst = 1;
        #1;
        n_checks++; if (level !== 5'd0)   begin n_fail++; $display("FAIL arst_level got=%0d exp=0", level); end
        n_checks++; if (empty !== 1'b1)   begin n_fail++; $display("FAIL arst_empty got=%b exp=1", empty); end
        n_checks++; if (trc_state !== 2'd0) begin n_fail++; $display("FAIL arst_state got=%0d exp=0", trc_state); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got=%b exp=0", rd_valid); end
        n_checks++; if (triggered !== 1'b0) begin n_fail++; $display("FAIL arst_triggered got=%b exp=0", triggered); end
        @(posedge mclk);
        #1;
        puc_rst = 0;
        model_reset();
    endtask

    task automatic test_random();
        reset_dut();
        trig_en = 1; trig_pc = 16'h0104; post_cnt = 5'd5; trc_wrap = 1;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 149) == 0) begin
                trig_pc  = 16'h0100 + 16'(2 * $urandom_range(0, 7));
                post_cnt = 5'($urandom_range(0, 16));
                trc_wrap = 1'($urandom_range(0, 1));
                trig_en  = ($urandom_range(0, 3) != 0);
            end
            trc_en     = ($urandom_range(0, 39) != 0);
            trc_clr    = ($urandom_range(0, 59) == 0);
            decode     = 1'($urandom_range(0, 1));
            rd_req     = ($urandom_range(0, 9) < 4);
            pc         = 16'h0100 + 16'(2 * $urandom_range(0, 7));
            ir         = 16'($urandom);
            irq_detect = ($urandom_range(0, 7) == 0);
            irq_num    = 4'($urandom);
            cycle();
            n_checks++; if (level !== 5'(m_q.size())) begin n_fail++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, level, m_q.size()); end
            n_checks++; if (empty !== (m_q.size() == 0)) begin n_fail++; $display("FAIL rnd_empty c=%0d got=%b", c, empty); end
            n_checks++; if (full !== (m_q.size() == 16)) begin n_fail++; $display("FAIL rnd_full c=%0d got=%b", c, full); end
            n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL rnd_overflow c=%0d got=%b exp=%b", c, overflow, m_ovf); end
            n_checks++; if (triggered !== m_trig) begin n_fail++; $display("FAIL rnd_triggered c=%0d got=%b exp=%b", c, triggered, m_trig); end
            n_checks++; if (trc_state !== 2'(m_state)) begin n_fail++; $display("FAIL rnd_state c=%0d got=%0d exp=%0d", c, trc_state, m_state); end
            n_checks++; if (rd_valid !== m_rd_valid) begin n_fail++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, rd_valid, m_rd_valid); end
            if (m_rd_valid) begin
                n_checks++; if (rd_data !== m_rd_data) begin n_fail++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, rd_data, m_rd_data); end
            end
        end
        trc_clr = 0; decode = 0; rd_req = 0; irq_detect = 0;
    endtask

    initial begin
        test_reset();
        test_cycle_delta();
        test_fill(1'b0);
        test_fill(1'b1);
        test_trigger();
        test_irq_full_pop();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/omsp_trace_buffer.md
Name: omsp_trace_buffer

Overview:
- Synthesizable on-chip instruction trace capture for one MSP430 core.
- Sits downstream of the core frontend and consumes the same decode strobe, IR, PC and IRQ status that the simulation debug monitor decodes.
- Stores one entry per decoded instruction in a circular buffer, with a PC-match trigger and post-trigger window.
- The buffer is drained through a pop/valid read port by the debug interface.

Parameters:
- DEPTH_LOG2, 4, log2 of buffer depth (DEPTH = 16 entries).
- CYC_W, 8, width of the per-entry cycle-delta field.

Ports:
- mclk  in  1  core clock
- puc_rst  in  1  reset
- decode  in  1  instruction decode strobe, one mclk pulse per instruction/IRQ
- ir  in  16  instruction register at decode
- pc  in  16  program counter at decode
- irq_detect  in  1  decode is an interrupt entry
- irq_num  in  4  interrupt number
- trc_en  in  1  capture enable (level)
- trc_wrap  in  1  1 = overwrite oldest when full, 0 = stop when full
- trc_clr  in  1  synchronous flush pulse
- trig_en  in  1  enable PC trigger
- trig_pc  in  16  trigger PC
- post_cnt  in  DEPTH_LOG2+1  entries captured after the trigger entry
- rd_req  in  1  pop request
- rd_data  out  37+CYC_W  {irq, irq_num, pc, ir, cyc}, MSB first
- rd_valid  out  1  rd_data valid (1-cycle pulse)
- level  out  DEPTH_LOG2+1  stored entry count, 0..DEPTH
- empty, full  out  1  level==0 / level==DEPTH
- overflow  out  1  sticky: an entry was lost or overwritten
- triggered  out  1  sticky: trigger has fired
- trc_state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE

Behaviour:
- Reset: puc_rst, asynchronous, active-high; clock mclk. All outputs reset to 0 except empty, which resets to 1. Pointers, cycle counter and post counter reset to 0. Reset mid-operation discards all contents.
- Capture condition: cap = decode & (trc_state==ARMED | trc_state==POST).
- Cycle delta:
  - Counter increments every mclk without decode and saturates at 2^CYC_W-1.
  - On decode, the current value goes into the entry's cyc field and the counter clears to 0.
  - The counter runs in every state.
- FSM:
  - IDLE -> ARMED when trc_en=1.
  - ARMED -> POST on a cap with trig_en=1 and pc==trig_pc. The trigger entry itself is stored, triggered is set, and remaining is loaded with post_cnt.
  - ARMED -> DONE instead of POST if post_cnt==0.
  - POST: each cap stores an entry and decrements remaining. The cap that brings remaining to 0 goes to DONE.
  - DONE: no capture; contents stay readable.
  - Any state -> IDLE when trc_en=0. Contents, triggered and overflow are kept.
- Write rules:
  - Not full: write at wr_ptr, level+1.
  - Full, trc_wrap=1: overwrite oldest, advance both pointers, level stays DEPTH, overflow set.
  - Full, trc_wrap=0: entry dropped, overflow set.
  - Full with simultaneous write and pop: both are accepted, no overflow.
- Read:
  - rd_req with !empty pops the oldest entry. rd_data is registered and rd_valid=1 the next cycle.
  - rd_req while empty is ignored; rd_valid stays 0.
  - Write and pop in the same cycle: level unchanged. A write into an empty buffer is readable from the next cycle.
  - rd_data holds its last value when rd_valid=0.
- Pointers wrap modulo DEPTH.
- trc_clr:
  - Clears pointers, level, overflow, triggered and remaining.
  - State goes to ARMED if trc_en=1, else IDLE.
  - Priority over a same-cycle cap or rd_req (both discarded).
- trig_en=0: ARMED captures indefinitely and never triggers.

Test Plan:
1. Reset, trc_en=1, 3 decodes spaced 1, 4, 300 cycles apart, then pop 3 -> rd_valid 3 pulses, oldest first, cyc fields per counter rule, third cyc=255 (saturated), empty=1 afterwards.
2. trc_wrap=0, 20 decodes with pc 0x0000..0x0013 -> level=16, full=1, overflow=1, pops return pc 0x0000..0x000F.
3. trc_wrap=1, same stimulus -> level=16, overflow=1, pops return pc 0x0004..0x0013.
4. trig_en=1, trig_pc=0xF010, post_cnt=2, decodes at pc 0xF00C, 0xF00E, 0xF010, 0xF012, 0xF014, 0xF016 -> 5 entries stored (0xF00C..0xF014), triggered=1, trc_state=DONE.
5. irq_detect=1, irq_num=0xE at decode, plus a same-cycle pop of a full buffer -> entry irq=1, irq_num=0xE; level stays 16; overflow stays 0.
6. Assert puc_rst asynchronously with level=7 and trc_state=POST -> immediately level=0, empty=1, trc_state=IDLE, rd_valid=0, triggered=0.
